// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX between NUM_REQ byte producers.
// Accepts one byte per frame over per-requester valid/ready handshakes,
// strobes it into the TX and then tracks tx_busy until the frame ends.
// Build option: define UART_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest valid index always wins. The default is round-robin.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_busy,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_data_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          arb_busy,
  output logic                          tx_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
  logic                  win_found;
  logic [ID_W-1:0]       win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic [ID_W-1:0]       search_base;
  logic [NUM_REQ-1:0]    req_ready_c;
  logic                  tx_err_c;

  // Unpack the flat data bus into one byte per requester
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_bytes[k] = req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef UART_ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  assign search_base = ptr_q;
`endif

  // Winner search: first valid index at or above the base, wrapping modulo NUM_REQ
  always_comb begin
    logic [ID_W:0] pos;
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    pos       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, search_base} + (ID_W+1)'(k);
      if (pos >= (ID_W+1)'(NUM_REQ)) begin
        pos = pos - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[pos[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[ID_W-1:0];
        win_data  = req_bytes[pos[ID_W-1:0]];
      end
    end
  end

  // Next-state, handshake and timeout logic
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    req_ready_c = '0;
    tx_err_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_busy && win_found) begin
          req_ready_c[win_idx] = 1'b1;
          tx_data_d            = win_data;
          grant_d              = win_idx;
`ifndef UART_ARB_FIXED_PRIO_EN
          ptr_d = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT-1)) begin
          tx_err_c = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_data_q <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Ready is gated by rst so no handshake can complete while reset is held
  assign req_ready     = rst ? '0 : req_ready_c;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = (state_q == S_ISSUE);
  assign grant_id      = grant_q;
  assign arb_busy      = (state_q != S_IDLE);
  assign tx_err        = tx_err_c;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// BUSY_TIMEOUT=4). The UART TX busy flag is driven from the stimulus sequence.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        tx_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .BUSY_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_busy(tx_busy),
    .tx_data(tx_data),
    .tx_data_valid(tx_data_valid),
    .grant_id(grant_id),
    .arb_busy(arb_busy),
    .tx_err(tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_byte(input int idx, input logic [7:0] b);
    req_data[idx*8 +: 8] = b;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] b);
    exp_t e;
    e.id   = id;
    e.data = b;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("tx_data", 32'(tx_data), 32'(e.data));
      chk("grant_id", 32'(grant_id), 32'(e.id));
    end
  endtask

  // Wait for the strobe, score it, then emulate a TX frame of nbusy cycles
  task automatic run_frame(input int nbusy, input bit clr, input bit drop);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_data_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (arb_busy === 1'b0 && req_ready !== 4'b0000)
        chk("ready_onehot", 32'($onehot(req_ready)), 1);
      step();
    end
    chk("strobe_seen", 32'(seen), 1);
    if (!seen) return;
    pop_check();
    if (clr) req_valid = 4'b0000;
    step();
    chk("strobe_one_cycle", 32'(tx_data_valid), 0);
    tx_busy = 1'b1;
    #1;
    chk("no_ready_wait_busy", 32'(req_ready), 0);
    step();
    for (int i = 0; i < nbusy; i++) begin
      step();
      chk("no_ready_wait_done", 32'(req_ready), 0);
    end
    if (drop) tx_busy = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    tx_busy   = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;

    // Reset values, ready forced low even with every valid high
    step();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_data_valid", 32'(tx_data_valid), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_arb_busy", 32'(arb_busy), 0);
    chk("rst_tx_err", 32'(tx_err), 0);
    req_valid = 4'b0000;
    rst = 1'b0;
    step();

    // Single request from requester 2
    req_valid = 4'b0100;
    set_byte(2, 8'h3C);
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    push(2'd2, 8'h3C);
    run_frame(6, 1'b1, 1'b1);
    chk("single_arb_busy", 32'(arb_busy), 1);
    // Requester 1 waits until the frame has finished; pointer is now 3
    req_valid = 4'b0010;
    set_byte(1, 8'h5A);
    #1;
    chk("no_ready_in_wait_done", 32'(req_ready), 0);
    push(2'd1, 8'h5A);
    run_frame(5, 1'b1, 1'b0);

    // Asynchronous reset in the middle of WAIT_DONE
    req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    chk("midrst_arb_busy", 32'(arb_busy), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    chk("midrst_grant_id", 32'(grant_id), 0);
    chk("midrst_tx_data_valid", 32'(tx_data_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    step();
    rst = 1'b0;
    tx_busy = 1'b0;
    req_valid = 4'b0001;
    set_byte(0, 8'hA5);
    #1;
    chk("postrst_ready", 32'(req_ready), 32'h1);
    push(2'd0, 8'hA5);
    run_frame(4, 1'b1, 1'b1);

    // Fresh reset so the pointer starts at 0, then all four valid continuously
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_byte(0, 8'h10);
    set_byte(1, 8'h21);
    set_byte(2, 8'h32);
    set_byte(3, 8'h43);
    req_valid = 4'b1111;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) push(2'd0, 8'h10);
`else
    push(2'd0, 8'h10);
    push(2'd1, 8'h21);
    push(2'd2, 8'h32);
    push(2'd3, 8'h43);
    push(2'd0, 8'h10);
`endif
    for (int i = 0; i < 5; i++) run_frame(4, 1'b0, 1'b1);
    // Only requester 3 left valid
    req_valid = 4'b1000;
    push(2'd3, 8'h43);
    run_frame(4, 1'b1, 1'b1);

    // Blocked issue: TX still busy when IDLE is entered
    step();
    tx_busy = 1'b1;
    req_valid = 4'b0001;
    set_byte(0, 8'h55);
    #1;
    chk("blocked_ready", 32'(req_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("blocked_ready_hold", 32'(req_ready), 0);
      chk("blocked_idle", 32'(arb_busy), 0);
    end
    tx_busy = 1'b0;
    #1;
    chk("unblocked_ready", 32'(req_ready), 32'h1);
    push(2'd0, 8'h55);
    run_frame(4, 1'b1, 1'b1);

    // Busy timeout: tx_busy never rises after the strobe
    req_valid = 4'b0010;
    set_byte(1, 8'h66);
    step();
    chk("to_ready", 32'(req_ready), 32'h2);
    push(2'd1, 8'h66);
    step();
    chk("to_strobe", 32'(tx_data_valid), 1);
    pop_check();
    req_valid = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("to_no_err_early", 32'(tx_err), 0);
      chk("to_arb_busy", 32'(arb_busy), 1);
    end
    step();
    chk("to_err_pulse", 32'(tx_err), 1);
    step();
    chk("to_err_cleared", 32'(tx_err), 0);
    chk("to_back_idle", 32'(arb_busy), 0);
    // Next request is served normally
    req_valid = 4'b0100;
    set_byte(2, 8'h77);
    #1;
    chk("after_to_ready", 32'(req_ready), 32'h4);
    push(2'd2, 8'h77);
    run_frame(3, 1'b1, 1'b1);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
